pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline sequencer for the five-stage integer core. It collects stall requests from ID (load-use hazard) and EX (multi-cycle operations such as mult/div) plus flush requests from MEM (exceptions, redirects). It drives the per-stage stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. A small FSM owns multi-cycle EX occupancy, so EX units only pulse a start with a cycle count.

## Interface
- No parameters; widths come from the shared defines header (`RegBus` = 32).
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stallreq_id  in  1  level; ID detects a hazard this cycle
- ex_mc_start  in  1  pulse; EX accepted a multi-cycle op this cycle
- ex_mc_cycles  in  6  total cycles the op occupies EX (0 = treat as single-cycle)
- flush_req  in  1  pulse; discard all younger instructions
- flush_pc  in  32  redirect target, valid with flush_req
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage register
- flush  out  1  clear IF/ID, ID/EX, EX/MEM to NOP values
- new_pc  out  32  PC load value, meaningful only while flush=1
- ctrl_state  out  2  FSM state: 0 RUN, 1 EX_BUSY, 2 FLUSH

## Operation
- stall, flush and new_pc are combinational from the current state and inputs. State and counter are registered.
- Input priority is flush_req > ex_mc_start/EX_BUSY > stallreq_id.
- RUN:
  - flush_req: flush=1, new_pc=flush_pc, stall=0; next state FLUSH.
  - Otherwise, ex_mc_start with N=ex_mc_cycles≥2: stall=6'b001111; cnt←N−1; next state EX_BUSY.
  - ex_mc_start with N≤1 is ignored.
  - Otherwise, stallreq_id: stall=6'b000111; stay in RUN.
  - Otherwise stall=0.
- EX_BUSY:
  - stall=6'b001111. MEM and WB keep flowing, so the bubble drains.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - stallreq_id and ex_mc_start are ignored.
  - flush_req: flush=1, new_pc=flush_pc, stall=0, cnt←0; next state FLUSH. This aborts the multi-cycle op.
- FLUSH: a one-cycle settle state.
  - stall=0 and flush=0.
  - stallreq_id and ex_mc_start are ignored, because ID/EX hold bubbles.
  - flush_req: same response as in RUN; stay in FLUSH.
  - Otherwise, next state RUN.
- new_pc=0 whenever flush=0.
- cnt is a 6-bit counter and never wraps. N=63 gives exactly 63 stalled cycles.

## Timing
- Reset values (rst=1 at an edge): state RUN, cnt 0. After reset: stall=0, flush=0, new_pc=0, ctrl_state=0. perf_stall_cycles is 0 when `PIPE_CTRL_PERF_EN` is compiled in.
- Combinational outputs during a reset cycle follow the RUN decode of the current inputs. Stage registers apply their own reset.
- A multi-cycle op of N cycles holds stall=6'b001111 for exactly N consecutive cycles, counting the ex_mc_start cycle. RUN resumes on cycle N+1.
- ID hazard: stall asserted the same cycle as stallreq_id, for as long as it is held. There is no added latency.
- flush_req followed by flush_req in the next cycle: both redirects are honoured, and the second new_pc wins.
- rst asserted mid-EX_BUSY: cnt←0 and state RUN at the next edge. No stall leaks into the post-reset cycle.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds output perf_stall_cycles (out, 32): the count of cycles with stall[0]=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst.
- `PIPE_CTRL_PERF_EN` undefined: the port and the counter are absent, and the remaining behaviour is identical.

## Test plan
- Reset → stall=0, flush=0, new_pc=0, ctrl_state=0; with `PIPE_CTRL_PERF_EN`, perf_stall_cycles=0.
- stallreq_id held for 3 cycles → stall=6'b000111 for those 3 cycles, then 0. State stays RUN; perf count =3.
- ex_mc_start with ex_mc_cycles=5 → stall=6'b001111 for 5 cycles, ctrl_state=1 for cycles 2–5, then RUN with stall=0. stallreq_id pulsed in cycle 3 has no effect.
- ex_mc_start with ex_mc_cycles=1, and separately with 0 → stall=0 and state RUN in both cases.
- In EX_BUSY cycle 2 of 10, flush_req with flush_pc=32'h0000_0100 → same cycle: flush=1, new_pc=32'h100, stall=0. Next cycle ctrl_state=2, then RUN.
- flush_req, stallreq_id and ex_mc_start(N=4) all in the same RUN cycle → flush wins. No stall follows; FLUSH, then RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges ID/EX stall requests and MEM flush requests into
// per-stage stall/flush controls. Optional stall-cycle counter: PIPE_CTRL_PERF_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_mc_start,
  input  logic [5:0]  ex_mc_cycles,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [1:0]  ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles
`endif
);

  // No valid/ready handshakes here: stallreq_id is a level sampled every cycle,
  // ex_mc_start and flush_req are single-cycle pulses with their payloads
  // (ex_mc_cycles, flush_pc) valid only in that cycle; outputs are unthrottled.

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_EX = 6'b001111;

  state_t      state_q, state_d, cur_state;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  // During a reset cycle the outputs decode as RUN so nothing stale leaks out.
  assign cur_state = rst ? RUN : state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_o  = '0;
    flush_o  = 1'b0;
    new_pc_o = '0;
    case (cur_state)
      RUN: begin
        if (flush_req) begin
          flush_o  = 1'b1;
          new_pc_o = flush_pc;
          state_d  = FLUSH;
        end else if (ex_mc_start && (ex_mc_cycles >= 6'd2)) begin
          stall_o = STALL_EX;
          cnt_d   = ex_mc_cycles - 6'd1;
          state_d = EX_BUSY;
        end else if (stallreq_id) begin
          stall_o = STALL_ID;
        end
      end
      EX_BUSY: begin
        if (flush_req) begin
          flush_o  = 1'b1;
          new_pc_o = flush_pc;
          cnt_d    = '0;
          state_d  = FLUSH;
        end else begin
          stall_o = STALL_EX;
          cnt_d   = (cnt_q != 6'd0) ? (cnt_q - 6'd1) : 6'd0;
          if (cnt_q <= 6'd1) state_d = RUN;
        end
      end
      FLUSH: begin
        if (flush_req) begin
          flush_o  = 1'b1;
          new_pc_o = flush_pc;
          state_d  = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall      = stall_o;
  assign flush      = flush_o;
  assign new_pc     = new_pc_o;
  assign ctrl_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall_o[0] && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expected outputs go into a queue and a
// negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  logic [40:0] exp_q[$];
  int          n_chk;
  int          n_fail;
  logic [31:0] perf_exp;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ctrl_state   (ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic cyc(input logic r, input logic sid, input logic st,
                     input logic [5:0] n, input logic fr, input logic [31:0] fpc,
                     input logic [1:0] es, input logic ef,
                     input logic [31:0] epc, input logic [5:0] estall);
    rst          = r;
    stallreq_id  = sid;
    ex_mc_start  = st;
    ex_mc_cycles = n;
    flush_req    = fr;
    flush_pc     = fpc;
    exp_q.push_back({es, ef, epc, estall});
    @(posedge clk);
    #1;
    if (r) perf_exp = 32'd0;
    else if (estall[0]) perf_exp = perf_exp + 32'd1;
  endtask

  task automatic idle(input logic [1:0] es);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, es, 1'b0, 32'd0, 6'b000000);
  endtask

  task automatic chk_perf(input string name);
`ifdef PIPE_CTRL_PERF_EN
    n_chk++;
    if (perf_stall_cycles !== perf_exp) begin
      n_fail++;
      $display("FAIL %s: perf_stall_cycles=%0d expected %0d", name, perf_stall_cycles, perf_exp);
    end
`else
    if (name.len() == 0) perf_exp = perf_exp;
`endif
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [40:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if ({ctrl_state, flush, new_pc, stall} !== e) begin
        n_fail++;
        $display("FAIL cycle_out @%0t: got state=%0d flush=%b new_pc=%h stall=%b, expected state=%0d flush=%b new_pc=%h stall=%b",
                 $time, ctrl_state, flush, new_pc, stall, e[40:39], e[38], e[37:6], e[5:0]);
      end
    end
  end

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    perf_exp     = 32'd0;
    rst          = 1'b1;
    stallreq_id  = 1'b0;
    ex_mc_start  = 1'b0;
    ex_mc_cycles = 6'd0;
    flush_req    = 1'b0;
    flush_pc     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_perf("reset_perf");

    // post-reset idle
    idle(2'd0);

    // ID hazard for 3 cycles
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 6'b000111);
    idle(2'd0);
    chk_perf("id_hazard_perf");

    // 5-cycle EX op; ID hazard and a second start in cycle 3 are ignored
    cyc(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 6'b001111);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, 2'd1, 1'b0, 32'd0, 6'b001111);
    cyc(1'b0, 1'b1, 1'b1, 6'd9, 1'b0, 32'd0, 2'd1, 1'b0, 32'd0, 6'b001111);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, 2'd1, 1'b0, 32'd0, 6'b001111);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, 2'd1, 1'b0, 32'd0, 6'b001111);
    idle(2'd0);

    // N=1 and N=0 act as single-cycle
    cyc(1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 6'b000000);
    idle(2'd0);
    cyc(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 6'b000000);
    idle(2'd0);

    // flush in cycle 2 of a 10-cycle op
    cyc(1'b0, 1'b0, 1'b1, 6'd10, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 6'b001111);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0100, 2'd1, 1'b1, 32'h0000_0100, 6'b000000);
    idle(2'd2);
    idle(2'd0);
    idle(2'd0);

    // flush + ID hazard + start all at once
    cyc(1'b0, 1'b1, 1'b1, 6'd4, 1'b1, 32'h0000_0200, 2'd0, 1'b1, 32'h0000_0200, 6'b000000);
    idle(2'd2);
    idle(2'd0);

    // back-to-back flushes, second target wins
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0300, 2'd0, 1'b1, 32'h0000_0300, 6'b000000);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0400, 2'd2, 1'b1, 32'h0000_0400, 6'b000000);
    idle(2'd2);
    idle(2'd0);

    // FLUSH ignores ID hazard and EX start
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0500, 2'd0, 1'b1, 32'h0000_0500, 6'b000000);
    cyc(1'b0, 1'b1, 1'b1, 6'd3, 1'b0, 32'd0, 2'd2, 1'b0, 32'd0, 6'b000000);
    idle(2'd0);

    // N=2 boundary
    cyc(1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 6'b001111);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, 2'd1, 1'b0, 32'd0, 6'b001111);
    idle(2'd0);

    // N=63: exactly 63 stalled cycles
    cyc(1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 6'b001111);
    repeat (62) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, 2'd1, 1'b0, 32'd0, 6'b001111);
    idle(2'd0);
    chk_perf("long_op_perf");

    // reset in the middle of EX_BUSY: outputs decode as RUN during reset
    cyc(1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 6'b001111);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, 2'd1, 1'b0, 32'd0, 6'b001111);
    cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'd0, 2'd1, 1'b0, 32'd0, 6'b000111);
    chk_perf("reset_clears_perf");
    idle(2'd0);
    idle(2'd0);
    chk_perf("final_perf");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
